// File: rtl/counter_conv_if.sv
// Handshake/result bundle between the conversion counter, the comparator
// front end and the result readout.
interface counter_conv_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic             en;
    logic             cmp;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             overflow;

    modport master (
        output start, abort, en, cmp,
        input  count, busy, result, result_valid, overflow
    );

    modport slave (
        input  start, abort, en, cmp,
        output count, busy, result, result_valid, overflow
    );
endinterface

// File: rtl/counter_conv.sv
// Single-slope conversion counter: counts from start until the comparator
// trips (after a blanking window) and captures the count as the result.
module counter_conv #(
    parameter int WIDTH        = 8,
    parameter int MAX_COUNT    = 2**WIDTH - 1,
    parameter int BLANK_CYCLES = 2,
    parameter int GRAY         = 0
) (
    input  logic          clk,
    input  logic          rst,
    counter_conv_if.slave bus
);
    localparam int BW = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MAX_COUNT);
    localparam logic [BW-1:0]    BLANK_LOAD = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    state_t           state_r;
    logic [BW-1:0]    blank_cnt_r;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] result_r;
    logic             result_valid_r;
    logic             overflow_r;
    logic             busy_r;

    // Ripple of half adders; the top carry is never formed since the
    // terminal-count check stops the count before it could wrap.
    function automatic logic [WIDTH-1:0] incr(input logic [WIDTH-1:0] a, input logic ci);
        logic [WIDTH-1:0] c_s;
        logic [WIDTH-1:0] s_s;
        c_s    = {WIDTH{1'b0}};
        c_s[0] = ci;
        for (int i = 0; i < WIDTH; i++) begin
            s_s[i] = a[i] ^ c_s[i];
            if (i < WIDTH - 1) begin
                c_s[i+1] = a[i] & c_s[i];
            end else begin
                c_s[0] = c_s[0];
            end
        end
        return s_s;
    endfunction

    function automatic logic [WIDTH-1:0] enc(input logic [WIDTH-1:0] c);
        if (GRAY != 0) begin
            return c ^ (c >> 1);
        end else begin
            return c;
        end
    endfunction

    // Conversion sequencer with registered count, result and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            blank_cnt_r    <= {BW{1'b0}};
            count_r        <= {WIDTH{1'b0}};
            result_r       <= {WIDTH{1'b0}};
            result_valid_r <= 1'b0;
            overflow_r     <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        count_r    <= {WIDTH{1'b0}};
                        overflow_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (BLANK_CYCLES == 0) begin
                            state_r <= ST_COUNT;
                        end else begin
                            state_r     <= ST_BLANK;
                            blank_cnt_r <= BLANK_LOAD;
                        end
                    end
                end
                ST_BLANK: begin
                    if (bus.abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (blank_cnt_r == {BW{1'b0}}) begin
                        state_r <= ST_COUNT;
                    end else begin
                        blank_cnt_r <= blank_cnt_r - BW'(1);
                    end
                end
                ST_COUNT: begin
                    if (bus.abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (bus.cmp) begin
                        result_r       <= enc(count_r);
                        overflow_r     <= 1'b0;
                        result_valid_r <= 1'b1;
                        state_r        <= ST_IDLE;
                        busy_r         <= 1'b0;
                    end else if (bus.en && (count_r == MAX_VAL)) begin
                        result_r       <= enc(MAX_VAL);
                        overflow_r     <= 1'b1;
                        result_valid_r <= 1'b1;
                        state_r        <= ST_IDLE;
                        busy_r         <= 1'b0;
                    end else begin
                        count_r <= incr(count_r, bus.en);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count        = count_r;
    assign bus.busy         = busy_r;
    assign bus.result       = result_r;
    assign bus.result_valid = result_valid_r;
    assign bus.overflow     = overflow_r;
endmodule

// File: tb/tb_counter_conv.sv
// Bench for counter_conv: two instances (binary with MAX_COUNT=100, Gray with
// full range) share directed stimulus and are checked against a cycle model.
module tb_counter_conv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic en = 1'b1;
    logic cmp = 1'b0;

    int tests = 0;
    int fails = 0;

    counter_conv_if #(.WIDTH(8)) bus0 ();
    counter_conv_if #(.WIDTH(8)) bus1 ();

    assign bus0.start = start;
    assign bus0.abort = abort;
    assign bus0.en    = en;
    assign bus0.cmp   = cmp;
    assign bus1.start = start;
    assign bus1.abort = abort;
    assign bus1.en    = en;
    assign bus1.cmp   = cmp;

    counter_conv #(.WIDTH(8), .MAX_COUNT(100), .BLANK_CYCLES(2), .GRAY(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    counter_conv #(.WIDTH(8), .MAX_COUNT(255), .BLANK_CYCLES(2), .GRAY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    always #5 clk = ~clk;

    // Conversion model: phase 0 idle, 1 blanking, 2 counting.
    typedef struct {
        int phase;
        int since;
        int count;
        int result;
        bit valid;
        bit ov;
    } m_t;

    m_t m0;
    m_t m1;

    function automatic int gray_of(int c, int g);
        return (g != 0) ? (c ^ (c >> 1)) : c;
    endfunction

    function automatic m_t step(m_t s, int maxv, int g, int blank,
                                bit st, bit ab, bit e, bit cp);
        m_t r;
        r = s;
        r.valid = 1'b0;
        if (s.phase == 0) begin
            if (st && !ab) begin
                r.count = 0;
                r.ov    = 1'b0;
                r.since = 0;
                r.phase = (blank > 0) ? 1 : 2;
            end
        end else if (s.phase == 1) begin
            if (ab) begin
                r.phase = 0;
            end else begin
                r.since = s.since + 1;
                if (r.since >= blank) r.phase = 2;
            end
        end else begin
            if (ab) begin
                r.phase = 0;
            end else if (cp) begin
                r.result = gray_of(s.count, g);
                r.ov = 1'b0;
                r.valid = 1'b1;
                r.phase = 0;
            end else if (e && s.count == maxv) begin
                r.result = gray_of(maxv, g);
                r.ov = 1'b1;
                r.valid = 1'b1;
                r.phase = 0;
            end else if (e) begin
                r.count = s.count + 1;
            end
        end
        return r;
    endfunction

    function automatic m_t zero_m();
        m_t r;
        r.phase = 0; r.since = 0; r.count = 0; r.result = 0; r.valid = 1'b0; r.ov = 1'b0;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= zero_m();
            m1 <= zero_m();
        end else begin
            m0 <= step(m0, 100, 0, 2, start, abort, en, cmp);
            m1 <= step(m1, 255, 1, 2, start, abort, en, cmp);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("d0_count", int'(bus0.count), m0.count);
        chk("d0_busy", int'(bus0.busy), int'(m0.phase != 0));
        chk("d0_result", int'(bus0.result), m0.result);
        chk("d0_valid", int'(bus0.result_valid), int'(m0.valid));
        chk("d0_ovf", int'(bus0.overflow), int'(m0.ov));
        chk("d1_count", int'(bus1.count), m1.count);
        chk("d1_busy", int'(bus1.busy), int'(m1.phase != 0));
        chk("d1_result", int'(bus1.result), m1.result);
        chk("d1_valid", int'(bus1.result_valid), int'(m1.valid));
        chk("d1_ovf", int'(bus1.overflow), int'(m1.ov));
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic begin_conv();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
    endtask

    initial begin
        #1;
        chk("rst_count", int'(bus0.count), 0);
        chk("rst_busy", int'(bus0.busy), 0);
        chk("rst_result", int'(bus0.result), 0);
        chk("rst_valid", int'(bus0.result_valid), 0);
        chk("rst_ovf", int'(bus0.overflow), 0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Trip at 37.
        begin_conv();
        tick(37);
        chk("t37_count", int'(bus0.count), 37);
        cmp = 1'b1;
        tick(1);
        cmp = 1'b0;
        chk("t37_result", int'(bus0.result), 37);
        chk("t37_valid", int'(bus0.result_valid), 1);
        chk("t37_busy", int'(bus0.busy), 0);
        chk("t37_ovf", int'(bus0.overflow), 0);
        chk("t37_gray", int'(bus1.result), 55);
        tick(1);
        chk("t37_pulse", int'(bus0.result_valid), 0);

        // cmp held through blanking: capture 0 on first counting cycle.
        cmp = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("blank_busy", int'(bus0.busy), 1);
        chk("blank_valid", int'(bus0.result_valid), 0);
        tick(2);
        chk("blank_noval", int'(bus0.result_valid), 0);
        tick(1);
        cmp = 1'b0;
        chk("blank_result", int'(bus0.result), 0);
        chk("blank_valid2", int'(bus0.result_valid), 1);

        // Terminal count without trip.
        begin_conv();
        tick(100);
        chk("ovf_count", int'(bus0.count), 100);
        tick(1);
        chk("ovf_result", int'(bus0.result), 100);
        chk("ovf_flag", int'(bus0.overflow), 1);
        chk("ovf_valid", int'(bus0.result_valid), 1);
        tick(3);
        chk("ovf_hold", int'(bus0.count), 100);
        chk("ovf_d1_busy", int'(bus1.busy), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_d1_busy", int'(bus1.busy), 0);
        chk("abort_d1_valid", int'(bus1.result_valid), 0);

        // Trip exactly at terminal count.
        begin_conv();
        tick(100);
        cmp = 1'b1;
        tick(1);
        cmp = 1'b0;
        chk("tc_result", int'(bus0.result), 100);
        chk("tc_ovf", int'(bus0.overflow), 0);
        chk("tc_gray", int'(bus1.result), 86);

        // en toggling with stray start pulses.
        begin_conv();
        for (int k = 0; k < 40; k++) begin
            en = (k % 2 == 0);
            start = (k % 7 == 3);
            tick(1);
        end
        start = 1'b0;
        chk("en_count", int'(bus0.count), 20);
        en = 1'b0;
        cmp = 1'b1;
        tick(1);
        cmp = 1'b0;
        en = 1'b1;
        chk("en_result", int'(bus0.result), 20);
        chk("en_gray", int'(bus1.result), 30);

        // Start accepted in the result_valid cycle; Gray trip at 12.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("restart_busy", int'(bus0.busy), 1);
        tick(2);
        tick(12);
        chk("g12_count", int'(bus1.count), 12);
        cmp = 1'b1;
        tick(1);
        cmp = 1'b0;
        chk("g12_result", int'(bus1.result), 10);
        chk("g12_bin", int'(bus0.result), 12);

        // Abort at 50 keeps the old result.
        begin_conv();
        tick(50);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("ab_busy", int'(bus0.busy), 0);
        chk("ab_valid", int'(bus0.result_valid), 0);
        chk("ab_result", int'(bus0.result), 12);
        chk("ab_count", int'(bus0.count), 50);

        // Asynchronous reset mid-conversion at 9.
        begin_conv();
        tick(9);
        chk("pre_rst_count", int'(bus0.count), 9);
        rst = 1'b1;
        #1;
        chk("arst_count", int'(bus0.count), 0);
        chk("arst_busy", int'(bus0.busy), 0);
        chk("arst_result", int'(bus0.result), 0);
        chk("arst_valid", int'(bus0.result_valid), 0);
        tick(1);
        rst = 1'b0;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
